// File: rtl/cpu_run_ctrl.sv
// CPU run controller: sequences the core's reset and clock enable and
// supports free-run, single-step, counted-run and soft-reset operations.
module cpu_run_ctrl #(
    parameter int CNT_W      = 16,
    parameter int RST_HOLD   = 4,
    parameter int DEF_CYCLES = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] n_cycles,
    output logic             cpu_rst,
    output logic             cpu_ce,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (RST_HOLD > 1) ? HOLD_W'(RST_HOLD - 1) : '0;
    localparam logic [CNT_W-1:0]  DEF_N     = CNT_W'(DEF_CYCLES);

    typedef enum logic [2:0] {
        S_HOLD,
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_FREE  = 2'b00,
        M_STEP  = 2'b01,
        M_COUNT = 2'b10,
        M_SOFT  = 2'b11
    } mode_t;

    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_counted;
    logic              r_soft;
    logic [CNT_W-1:0]  r_n;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cpu_rst;
    logic              r_cpu_ce;
    logic              r_busy;
    logic              r_done;

    mode_t             w_mode;
    logic [CNT_W:0]    w_cnt_inc;
    logic [CNT_W-1:0]  w_cnt_sat;
    logic              w_last;
    logic              w_hold_end;

    // Next-count arithmetic and end-of-phase conditions
    always_comb begin
        w_mode     = mode_t'(mode);
        w_cnt_inc  = {1'b0, r_cnt} + (CNT_W + 1)'(1);
        w_cnt_sat  = (&r_cnt) ? r_cnt : w_cnt_inc[CNT_W-1:0];
        // The cycle now in progress is the N-th enabled cycle of a counted run
        w_last     = r_counted && (w_cnt_inc == {1'b0, r_n});
        w_hold_end = (r_hold_cnt >= HOLD_LAST);
    end

    // Run-control state machine with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
            r_counted  <= 1'b0;
            r_soft     <= 1'b0;
            r_n        <= '0;
            r_cnt      <= '0;
            r_cpu_rst  <= 1'b1;
            r_cpu_ce   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_HOLD: begin
                    if (w_hold_end) begin
                        r_cpu_rst  <= 1'b0;
                        r_hold_cnt <= '0;
                        // A soft reset completes through DONE so it reports with a pulse
                        if (r_soft) begin
                            r_soft  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end

                S_IDLE: begin
                    if (start) begin
                        r_cnt     <= '0;
                        r_counted <= (w_mode == M_COUNT);
                        r_n       <= (n_cycles == '0) ? DEF_N : n_cycles;
                        case (w_mode)
                            M_FREE, M_COUNT: begin
                                r_state  <= S_RUN;
                                r_cpu_ce <= 1'b1;
                                r_busy   <= 1'b1;
                            end
                            M_STEP: begin
                                r_state  <= S_STEP;
                                r_cpu_ce <= 1'b1;
                                r_busy   <= 1'b1;
                            end
                            M_SOFT: begin
                                r_state    <= S_HOLD;
                                r_cpu_rst  <= 1'b1;
                                r_hold_cnt <= '0;
                                r_soft     <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                S_RUN: begin
                    // cpu_ce is high for the whole RUN state, so every cycle counts;
                    // stop and the final counted cycle share one exit path
                    r_cnt <= w_cnt_sat;
                    if (stop || w_last) begin
                        r_state  <= S_DONE;
                        r_cpu_ce <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end

                S_STEP: begin
                    r_cnt    <= w_cnt_sat;
                    r_state  <= S_DONE;
                    r_cpu_ce <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state    <= S_HOLD;
                    r_hold_cnt <= '0;
                    r_cpu_rst  <= 1'b1;
                    r_cpu_ce   <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rst   = r_cpu_rst;
    assign cpu_ce    = r_cpu_ce;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cycle_cnt = r_cnt;

endmodule
